core_wb_writeback: RTL and testbench
====================================

# core_wb_writeback

Write-back stage controller that produces the register-file write port (`write_addr`/`write_data`/`write_en`) from two result producers, the ALU and the load/store unit. Results are accepted through valid/ready handshakes into a small in-order pending queue. The queue drains at one register write per cycle. The ID stage gets a forwarding lookup for values that are queued but not yet written, so its two register reads always see the newest value.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4. Pending-queue entries. Must be a power of 2 and ≥ 2.

Ports:
- `clk`  in  1  Clock; all state updates on the rising edge.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `alu_valid`  in  1  ALU result available.
- `alu_ready`  out  1  ALU result accepted this cycle when high with `alu_valid`.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result value.
- `lsu_valid`  in  1  Load result available.
- `lsu_ready`  out  1  Load result accepted this cycle when high with `lsu_valid`.
- `lsu_rd`  in  5  Load destination register.
- `lsu_data`  in  32  Load result value.
- `write_addr`  out  5  Register-file write address.
- `write_data`  out  32  Register-file write data.
- `write_en`  out  1  Register-file write strobe.
- `fwd_0_addr`  in  5  Forwarding lookup address 0, tied to read port 0 address.
- `fwd_0_hit`  out  1  A pending write to `fwd_0_addr` exists.
- `fwd_0_data`  out  32  Newest pending value for `fwd_0_addr`.
- `fwd_1_addr` / `fwd_1_hit` / `fwd_1_data`  in/out/out  5/1/32  Same as port 0, for read port 1.
- `pending_count`  out  $clog2(FIFO_DEPTH)+1  Number of queued entries.

## Operation
- The pending queue is a circular FIFO of {rd, data}, with read and write pointers that wrap modulo `FIFO_DEPTH`, plus an occupancy count.
- Ready signals depend only on registered occupancy and never on the valid inputs:
  - `lsu_ready = (count <= FIFO_DEPTH-1)`
  - `alu_ready = (count <= FIFO_DEPTH-2)`
  - This is conservative: a same-cycle pop is not credited.
- A push happens on each handshake (valid && ready).
- When both producers push in the same cycle, the LSU entry is enqueued first (older), then the ALU entry. Both enter in that one cycle.
- Results with rd == 0 complete the handshake but are not enqueued.
- Pop: whenever count > 0, the head entry is popped every cycle and drives the write port.
- Write port, combinational from the head:
  - `write_en = (count != 0)`
  - `write_addr` = head rd, `write_data` = head data
  - Both are 0 when the queue is empty.
- Count update: count_next = count + pushes − pop, where pushes ∈ {0,1,2} and pop ∈ {0,1}. It never exceeds `FIFO_DEPTH`.
- Forwarding is combinational:
  - All valid entries are searched, newest to oldest.
  - `fwd_N_hit` = 1 when the newest entry with rd == `fwd_N_addr` exists and `fwd_N_addr` != 0. `fwd_N_data` = that entry's data.
  - On a miss, hit = 0 and data = 0.
  - The head entry being written this cycle is included in the search.

## Timing
- Reset (rst_n low, any time, asynchronously) clears:
  - pointers and count to 0, so `write_en`=0, `write_addr`=0, `write_data`=0, `pending_count`=0;
  - `alu_ready`=1 and `lsu_ready`=1;
  - all `fwd_*_hit`=0 and `fwd_*_data`=0.
- Queued entries are discarded on reset, including mid-drain.
- Latency: a result accepted at edge N into an empty queue appears on the write port during cycle N+1. The register file captures it at edge N+1.
- Two simultaneous pushes into an empty queue: LSU is written at edge N+1, ALU at edge N+2.
- Full: while count == `FIFO_DEPTH`, both readies are 0. While count == `FIFO_DEPTH`−1, only the LSU is ready.
- Ready is re-evaluated every cycle from the registered count. There is no combinational path from valid to ready.
- Forwarding outputs update in the same cycle the queue changes, i.e. after the edge.

## Test plan
- Reset: hold rst_n=0 → all outputs 0 except both readies = 1. Release → write_en stays 0 with no traffic.
- Single ALU push rd=5, data=0xDEADBEEF at edge N → write_en=1, write_addr=5, write_data=0xDEADBEEF during cycle N+1 only. pending_count goes 1→0.
- Simultaneous push LSU rd=3 data=0x11 and ALU rd=3 data=0x22 → writes to rd=3 in order 0x11 then 0x22. fwd_0_addr=3 returns 0x22 while both are queued and 0x22 while only the ALU entry remains.
- Sustained dual valid with `FIFO_DEPTH`=4 → count 0→2→3, then alu_ready=0 and lsu_ready=1. Steady-state count stays 3 and no entry is lost or reordered.
- rd=0 push with data=0xFFFFFFFF → handshake completes, no write_en pulse, fwd lookup of 0 gives hit=0.
- With 3 entries queued, pulse rst_n low mid-cycle → outputs clear immediately, no further writes, pending_count=0.

Source files
------------

// File: rtl/core_wb_writeback.sv
// core_wb_writeback
// Write-back stage controller. ALU and LSU results enter a small in-order
// pending queue through valid/ready handshakes. The queue drains one
// register-file write per cycle. A forwarding lookup lets the ID stage see
// results that are queued but not yet written.

module core_wb_writeback #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,

   input  logic                            alu_valid,
   output logic                            alu_ready,
   input  logic [4:0]                      alu_rd,
   input  logic [31:0]                     alu_data,

   input  logic                            lsu_valid,
   output logic                            lsu_ready,
   input  logic [4:0]                      lsu_rd,
   input  logic [31:0]                     lsu_data,

   output logic [4:0]                      write_addr,
   output logic [31:0]                     write_data,
   output logic                            write_en,

   input  logic [4:0]                      fwd_0_addr,
   output logic                            fwd_0_hit,
   output logic [31:0]                     fwd_0_data,
   input  logic [4:0]                      fwd_1_addr,
   output logic                            fwd_1_hit,
   output logic [31:0]                     fwd_1_data,

   output logic [$clog2(FIFO_DEPTH):0]     pending_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   logic [4:0]    mem_rd_q   [FIFO_DEPTH];
   logic [4:0]    mem_rd_d   [FIFO_DEPTH];
   logic [31:0]   mem_data_q [FIFO_DEPTH];
   logic [31:0]   mem_data_d [FIFO_DEPTH];

   logic          lsu_push;
   logic          alu_push;
   logic          pop;
   logic [AW-1:0] fwd_idx;

   // Readiness comes only from the registered occupancy. A same-cycle pop is
   // not credited, so there is never a path from valid to ready. The ALU
   // needs two free slots because it may arrive alongside an LSU result.
   assign lsu_ready = (count_q <= CW'(FIFO_DEPTH - 1));
   assign alu_ready = (count_q <= CW'(FIFO_DEPTH - 2));

   // Results targeting x0 finish the handshake but are discarded.
   assign lsu_push = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
   assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
   assign pop      = (count_q != '0);

   // Write port, driven straight from the queue head.
   assign write_en      = pop;
   assign write_addr    = pop ? mem_rd_q[rd_ptr_q]   : 5'd0;
   assign write_data    = pop ? mem_data_q[rd_ptr_q] : 32'd0;
   assign pending_count = count_q;

   // Next-state for the queue: LSU enqueues first (older), then the ALU.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      mem_rd_d   = mem_rd_q;
      mem_data_d = mem_data_q;
      wr_ptr_d   = wr_ptr_q;
      // NOTE: blocking assignments inside always_comb let wr_ptr_d advance
      // between the two pushes; sequential blocks use non-blocking only.
      if (lsu_push) begin
         mem_rd_d[wr_ptr_d]   = lsu_rd;
         mem_data_d[wr_ptr_d] = lsu_data;
         wr_ptr_d             = wr_ptr_d + AW'(1);
      end
      if (alu_push) begin
         mem_rd_d[wr_ptr_d]   = alu_rd;
         mem_data_d[wr_ptr_d] = alu_data;
         wr_ptr_d             = wr_ptr_d + AW'(1);
      end
      rd_ptr_d = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      count_d  = count_q + CW'(lsu_push) + CW'(alu_push) - CW'(pop);
   end

   // Forwarding: scan valid entries oldest to newest so the newest match
   // overwrites any older one. The head being written this cycle is included.
   always_comb begin
      fwd_0_hit  = 1'b0;
      fwd_0_data = 32'd0;
      fwd_1_hit  = 1'b0;
      fwd_1_data = 32'd0;
      fwd_idx    = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         fwd_idx = rd_ptr_q + AW'(i);
         if (CW'(i) < count_q) begin
            if ((fwd_0_addr != 5'd0) && (mem_rd_q[fwd_idx] == fwd_0_addr)) begin
               fwd_0_hit  = 1'b1;
               fwd_0_data = mem_data_q[fwd_idx];
            end
            if ((fwd_1_addr != 5'd0) && (mem_rd_q[fwd_idx] == fwd_1_addr)) begin
               fwd_1_hit  = 1'b1;
               fwd_1_data = mem_data_q[fwd_idx];
            end
         end
      end
   end

   // Pointer and occupancy state; reset empties the queue immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Queue storage.
   // NOTE: storage is deliberately not reset; entries are only ever read
   // when the count marks them valid, so stale contents are never visible.
   always_ff @(posedge clk) begin
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
   end

endmodule

// File: tb/tb_core_wb_writeback.sv
// Testbench for core_wb_writeback: directed stimulus with a write-port
// scoreboard. Stimulus pushes expected register writes into a queue; a
// monitor pops and compares whenever write_en is seen.

module tb_core_wb_writeback;

   logic        clk;
   logic        rst_n;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid, lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic        write_en;
   logic [4:0]  fwd_0_addr, fwd_1_addr;
   logic        fwd_0_hit, fwd_1_hit;
   logic [31:0] fwd_0_data, fwd_1_data;
   logic [2:0]  pending_count;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  total = 0;
   int  bad   = 0;

   core_wb_writeback #(.FIFO_DEPTH(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_rd        (alu_rd),
      .alu_data      (alu_data),
      .lsu_valid     (lsu_valid),
      .lsu_ready     (lsu_ready),
      .lsu_rd        (lsu_rd),
      .lsu_data      (lsu_data),
      .write_addr    (write_addr),
      .write_data    (write_data),
      .write_en      (write_en),
      .fwd_0_addr    (fwd_0_addr),
      .fwd_0_hit     (fwd_0_hit),
      .fwd_0_data    (fwd_0_data),
      .fwd_1_addr    (fwd_1_addr),
      .fwd_1_hit     (fwd_1_hit),
      .fwd_1_data    (fwd_1_data),
      .pending_count (pending_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_write_en"},   32'(write_en),      32'd0);
      check({tag, "_write_addr"}, 32'(write_addr),    32'd0);
      check({tag, "_write_data"}, write_data,         32'd0);
      check({tag, "_pending"},    32'(pending_count), 32'd0);
      check({tag, "_alu_ready"},  32'(alu_ready),     32'd1);
      check({tag, "_lsu_ready"},  32'(lsu_ready),     32'd1);
      check({tag, "_fwd0_hit"},   32'(fwd_0_hit),     32'd0);
      check({tag, "_fwd0_data"},  fwd_0_data,         32'd0);
      check({tag, "_fwd1_hit"},   32'(fwd_1_hit),     32'd0);
      check({tag, "_fwd1_data"},  fwd_1_data,         32'd0);
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (write_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr=%0d data=0x%08h expected no write at %0t",
                     write_addr, write_data, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_write_addr", 32'(write_addr), 32'(mon_e.addr));
            check("sb_write_data", write_data, mon_e.data);
         end
      end
   end

   // Hand-computed sustained dual-valid sequence for FIFO_DEPTH=4.
   int exp_cnt     [6] = '{0, 2, 3, 3, 3, 3};
   int exp_alu_rdy [6] = '{1, 1, 0, 0, 0, 0};

   initial begin
      int alu_k;
      rst_n      = 1'b0;
      alu_valid  = 1'b0;
      alu_rd     = 5'd0;
      alu_data   = 32'd0;
      lsu_valid  = 1'b0;
      lsu_rd     = 5'd0;
      lsu_data   = 32'd0;
      fwd_0_addr = 5'd5;
      fwd_1_addr = 5'd3;

      // Reset state before any clock edge.
      #2;
      check_reset_outputs("reset");
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
      check("idle_write_en", 32'(write_en), 32'd0);
      cycle();
      check("idle_write_en2", 32'(write_en), 32'd0);

      // Single ALU push, rd=5.
      alu_valid  = 1'b1;
      alu_rd     = 5'd5;
      alu_data   = 32'hDEADBEEF;
      fwd_0_addr = 5'd5;
      check("single_alu_ready", 32'(alu_ready), 32'd1);
      push_exp(5'd5, 32'hDEADBEEF);
      cycle();
      alu_valid = 1'b0;
      check("single_pending1", 32'(pending_count), 32'd1);
      check("single_write_en", 32'(write_en),      32'd1);
      check("single_fwd_hit",  32'(fwd_0_hit),     32'd1);
      check("single_fwd_data", fwd_0_data,         32'hDEADBEEF);
      cycle();
      check("single_pending0", 32'(pending_count), 32'd0);
      check("single_write_en0", 32'(write_en),     32'd0);
      check("single_fwd_miss", 32'(fwd_0_hit),     32'd0);

      // Simultaneous push to rd=3: LSU older, ALU newer.
      lsu_valid  = 1'b1;
      lsu_rd     = 5'd3;
      lsu_data   = 32'h11;
      alu_valid  = 1'b1;
      alu_rd     = 5'd3;
      alu_data   = 32'h22;
      fwd_0_addr = 5'd3;
      fwd_1_addr = 5'd4;
      push_exp(5'd3, 32'h11);
      push_exp(5'd3, 32'h22);
      cycle();
      lsu_valid = 1'b0;
      alu_valid = 1'b0;
      check("dual_pending2",  32'(pending_count), 32'd2);
      check("dual_fwd_hit2",  32'(fwd_0_hit),     32'd1);
      check("dual_fwd_data2", fwd_0_data,         32'h22);
      check("dual_fwd1_miss", 32'(fwd_1_hit),     32'd0);
      cycle();
      check("dual_pending1",  32'(pending_count), 32'd1);
      check("dual_fwd_hit1",  32'(fwd_0_hit),     32'd1);
      check("dual_fwd_data1", fwd_0_data,         32'h22);
      cycle();
      check("dual_pending0",  32'(pending_count), 32'd0);
      check("dual_fwd_hit0",  32'(fwd_0_hit),     32'd0);
      check("dual_fwd_data0", fwd_0_data,         32'd0);

      // rd=0 push: handshake completes, nothing queued.
      alu_valid  = 1'b1;
      alu_rd     = 5'd0;
      alu_data   = 32'hFFFFFFFF;
      fwd_1_addr = 5'd0;
      check("rd0_alu_ready", 32'(alu_ready), 32'd1);
      cycle();
      alu_valid = 1'b0;
      check("rd0_pending",   32'(pending_count), 32'd0);
      check("rd0_write_en",  32'(write_en),      32'd0);
      check("rd0_fwd1_hit",  32'(fwd_1_hit),     32'd0);
      check("rd0_fwd1_data", fwd_1_data,         32'd0);
      cycle();
      check("rd0_write_en2", 32'(write_en), 32'd0);

      // Sustained dual valid: ALU stalls once three entries are queued.
      alu_k = 0;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("sus_pending_%0d", k),   32'(pending_count), 32'(exp_cnt[k]));
         check($sformatf("sus_alu_ready_%0d", k), 32'(alu_ready),     32'(exp_alu_rdy[k]));
         check($sformatf("sus_lsu_ready_%0d", k), 32'(lsu_ready),     32'd1);
         lsu_valid = 1'b1;
         lsu_rd    = 5'(1 + k);
         lsu_data  = 32'h100 + 32'(k);
         alu_valid = 1'b1;
         alu_rd    = 5'(20 + alu_k);
         alu_data  = 32'h200 + 32'(alu_k);
         push_exp(lsu_rd, lsu_data);
         if (exp_alu_rdy[k] == 1) begin
            push_exp(alu_rd, alu_data);
            alu_k++;
         end
         cycle();
      end
      lsu_valid = 1'b0;
      alu_valid = 1'b0;
      check("sus_pending_end", 32'(pending_count), 32'd3);
      cycle();
      check("sus_drain_2", 32'(pending_count), 32'd2);
      for (int n = 0; n < 20 && exp_q.size() != 0; n++) cycle();
      check("sus_drained", 32'(exp_q.size()), 32'd0);
      check("sus_pending_0", 32'(pending_count), 32'd0);

      // Reset mid-drain with three entries queued.
      lsu_valid = 1'b1;
      lsu_rd    = 5'd7;
      lsu_data  = 32'hA1;
      alu_valid = 1'b1;
      alu_rd    = 5'd8;
      alu_data  = 32'hA2;
      push_exp(5'd7, 32'hA1);
      push_exp(5'd8, 32'hA2);
      cycle();
      lsu_rd    = 5'd9;
      lsu_data  = 32'hA3;
      alu_rd    = 5'd10;
      alu_data  = 32'hA4;
      check("mid_alu_ready", 32'(alu_ready), 32'd1);
      push_exp(5'd9, 32'hA3);
      push_exp(5'd10, 32'hA4);
      cycle();
      lsu_valid  = 1'b0;
      alu_valid  = 1'b0;
      fwd_0_addr = 5'd10;
      fwd_1_addr = 5'd9;
      #1;
      check("mid_pending3",   32'(pending_count), 32'd3);
      check("mid_fwd0_hit",   32'(fwd_0_hit),     32'd1);
      check("mid_fwd0_data",  fwd_0_data,         32'hA4);
      check("mid_write_en",   32'(write_en),      32'd1);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_reset_outputs("midrst");
      cycle();
      check("midrst_hold_pending", 32'(pending_count), 32'd0);
      rst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         cycle();
         check($sformatf("post_rst_write_en_%0d", n), 32'(write_en), 32'd0);
      end

      check("final_sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
